// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus controller: funct3 codes, opcode
// pairs, FSM states and the access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Opcode pairs as {op_load, op_store}
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Unsigned variants exist only for loads; doubleword forms only at XLEN=64
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load, input int xlen);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return is_load;
      F3_D:             return (xlen == 64);
      F3_WU:            return is_load && (xlen == 64);
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: lane masks for up to two beats, store data shift, and
// load data merge/shift/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata_lo,
  input  logic [XLEN-1:0]  rdata_hi,
  output logic [NB-1:0]    mask_lo,
  output logic [NB-1:0]    mask_hi,
  output logic [XLEN-1:0]  wdata_lo,
  output logic [XLEN-1:0]  wdata_hi,
  output logic [XLEN-1:0]  load_data
);

  logic [3:0]        size;
  logic [2*NB-1:0]   lanes;
  logic [2*XLEN-1:0] wide_w;
  logic [2*XLEN-1:0] wide_r;
  logic [XLEN-1:0]   shifted;
  logic              ext_bit;

  assign size = size_bytes(funct3);

  // Lanes span a double-width window so a crossing access splits naturally
  for (genvar gi = 0; gi < 2 * NB; gi++) begin : g_lane
    assign lanes[gi] = (gi >= int'(offset)) && (gi < int'(offset) + int'(size));
  end

  assign mask_lo = lanes[NB-1:0];
  assign mask_hi = lanes[2*NB-1:NB];

  assign wide_w   = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
  assign wdata_lo = wide_w[XLEN-1:0];
  assign wdata_hi = wide_w[2*XLEN-1:XLEN];

  assign wide_r  = {rdata_hi, rdata_lo} >> {offset, 3'b000};
  assign shifted = wide_r[XLEN-1:0];

  always_comb begin
    ext_bit = 1'b0;
    case (size)
      4'd1:    ext_bit = shifted[7];
      4'd2:    ext_bit = shifted[15];
      4'd4:    ext_bit = shifted[31];
      default: ext_bit = shifted[XLEN-1];
    endcase
    ext_bit = ext_bit & ~funct3[2];
  end

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
    assign load_data[gi] = (gi < 8 * int'(size)) ? shifted[gi] : ext_bit;
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: one pipeline request becomes one (or two, with
// LSU_MISALIGN_SPLIT_EN defined) lane-aligned bus beats plus a one-cycle response.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              op_load,
  input  logic              op_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_mask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e        state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rlo_q, rlo_d;
  logic [XLEN-1:0]   rhi_q, rhi_d;
  logic              beat_q, beat_d;
  logic              split_q, split_d;

  logic              accept;
  logic [3:0]        in_size;
  logic [OFF_W-1:0]  in_off;
  logic              bad_op;
  logic              in_split;
  logic              req_err;

  logic [NB-1:0]     mask_lo, mask_hi;
  logic [XLEN-1:0]   wdata_lo, wdata_hi, load_data;

  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign stall     = (state_q != ST_IDLE) || accept;

  assign in_size = size_bytes(funct3);
  assign in_off  = addr[OFF_W-1:0];
  assign bad_op  = !({op_load, op_store} inside {OP_LOAD, OP_STORE}) ||
                   !f3_legal(funct3, op_load, XLEN);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign in_split = (int'(in_off) + int'(in_size)) > NB;
  assign req_err  = bad_op;
`else
  logic misalign;
  assign misalign = (4'(in_off) & (in_size - 4'd1)) != 4'd0;
  assign in_split = 1'b0;
  assign req_err  = bad_op || misalign;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .offset    (addr_q[OFF_W-1:0]),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .rdata_lo  (rlo_q),
    .rdata_hi  (rhi_q),
    .mask_lo   (mask_lo),
    .mask_hi   (mask_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .load_data (load_data)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rlo_d   = rlo_q;
    rhi_d   = rhi_q;
    beat_d  = beat_q;
    split_d = split_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          store_d = op_store;
          f3_d    = funct3;
          addr_d  = addr;
          wdata_d = wdata;
          rlo_d   = '0;
          rhi_d   = '0;
          beat_d  = 1'b0;
          split_d = in_split;
          state_d = req_err ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        // A granted store beat needs no return, so it never visits WAIT
        if (mem_gnt) begin
          if (!store_q) begin
            state_d = ST_WAIT;
          end else if (split_q && !beat_q) begin
            beat_d = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (beat_q) rhi_d = mem_rdata;
          else        rlo_d = mem_rdata;
          if (split_q && !beat_q) begin
            beat_d  = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
      rhi_q   <= '0;
      beat_q  <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rlo_q   <= rlo_d;
      rhi_q   <= rhi_d;
      beat_q  <= beat_d;
      split_q <= split_d;
    end
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = store_q;
  assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + (beat_q ? ADDR_W'(NB) : '0);
  assign mem_wdata = beat_q ? wdata_hi : wdata_lo;

  always_comb begin
    mem_mask = '0;
    mem_mask[NB-1:0] = beat_q ? mask_hi : mask_lo;
  end

  assign rsp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign rsp_err   = (state_q == ST_ERR);
  assign rsp_rdata = (state_q == ST_RESP && !store_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl at XLEN=32: a vector table of single-beat and
// error requests, then hand sequences for gnt back-pressure, reset and misalignment.
module tb_lsu_bus_ctrl;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              op_load = 1'b0;
  logic              op_store = 1'b0;
  logic [2:0]        funct3 = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [XLEN-1:0]   wdata = '0;
  logic              rsp_valid;
  logic              rsp_err;
  logic [XLEN-1:0]   rsp_rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_mask;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;

  lsu_bus_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_load    (op_load),
    .op_store   (op_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_mask   (mem_mask),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_addr;
    logic [7:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE and lets it be accepted on the next edge
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    op_load   = ld;
    op_store  = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    chk("stall_on_accept", {63'd0, stall}, 64'd1);
    chk("ready_idle", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    issue(v.ld, v.st, v.f3, v.addr, v.wdata);
    if (v.err) begin
      chk("err_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("err_rsp_err", {63'd0, rsp_err}, 64'd1);
      chk("err_no_mem_req", {63'd0, mem_req}, 64'd0);
    end else begin
      chk("mem_req", {63'd0, mem_req}, 64'd1);
      chk("mem_addr", 64'(mem_addr), 64'(v.e_addr));
      chk("mem_mask", 64'(mem_mask), 64'(v.e_mask));
      chk("mem_we", {63'd0, mem_we}, {63'd0, v.st});
      if (v.st) chk("mem_wdata", 64'(mem_wdata), 64'(v.e_wdata));
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      if (v.ld) begin
        chk("wait_no_req", {63'd0, mem_req}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("rsp_err", {63'd0, rsp_err}, 64'd0);
      chk("rsp_rdata", 64'(rsp_rdata), 64'(v.e_rdata));
    end
    $display("txn %0d ld=%0b st=%0b f3=%b addr=%h rsp_err=%0b rsp_rdata=%h",
             idx, v.ld, v.st, v.f3, v.addr, rsp_err, rsp_rdata);
    step();
    chk("rsp_pulse_end", {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    //          ld    st    f3      addr      wdata         rdata         err   e_addr    mask   e_wdata       e_rdata
    vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 32'h0,        1'b0, 32'h100, 8'h08, 32'hAB00_0000, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h8001_1234, 1'b0, 32'h100, 8'h0C, 32'h0,        32'hFFFF_8001};
    vecs[2]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h8001_1234, 1'b0, 32'h100, 8'h0C, 32'h0,        32'h0000_8001};
    vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h200, 8'h0F, 32'h0,        32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h201, 32'h0,        32'h1234_8056, 1'b0, 32'h200, 8'h02, 32'h0,        32'hFFFF_FF80};
    vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h7F00_0000, 1'b0, 32'h200, 8'h08, 32'h0,        32'h0000_007F};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234_BEEF, 32'h0,        1'b0, 32'h204, 8'h0C, 32'hBEEF_0000, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0,        1'b0, 32'h300, 8'h0F, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h300, 32'h0,        32'h0,        1'b1, 32'h0,   8'h00, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h300, 32'h0,        32'h0,        1'b1, 32'h0,   8'h00, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b0, 3'b010, 32'h300, 32'h0,        32'h0,        1'b1, 32'h0,   8'h00, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h300, 32'h0,        32'h0,        1'b1, 32'h0,   8'h00, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b111, 32'h300, 32'h0,        32'h0,        1'b1, 32'h0,   8'h00, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h003, 32'h0,        32'h0102_0304, 1'b0, 32'h000, 8'h08, 32'h0,        32'h0000_0001};

    // Reset state, with a request pending that must not raise stall
    req_valid = 1'b1;
    #1;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("post_rst_stall", {63'd0, stall}, 64'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // gnt withheld for five cycles: beat held stable, pipeline stalled
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_mem_req", {63'd0, mem_req}, 64'd1);
      chk("hold_mem_addr", 64'(mem_addr), 64'h400);
      chk("hold_mem_mask", 64'(mem_mask), 64'h0F);
      chk("hold_stall", {63'd0, stall}, 64'd1);
      chk("hold_ready", {63'd0, req_ready}, 64'd0);
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0055;
    step();
    mem_rvalid = 1'b0;
    chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("hold_rsp_rdata", 64'(rsp_rdata), 64'h55);
    $display("txn hold: LW addr=00000400 after 5 gnt-low cycles rsp_rdata=%h", rsp_rdata);
    step();

    // Reset while waiting for read data; the late rvalid must be ignored
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("wait_stall", {63'd0, stall}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("arst_stall", {63'd0, stall}, 64'd0);
    chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    chk("late_rvalid_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("late_rvalid_ready", {63'd0, req_ready}, 64'd1);
    chk("late_rvalid_req", {63'd0, mem_req}, 64'd0);
    step();
    chk("late_rvalid_rsp2", {63'd0, rsp_valid}, 64'd0);
    $display("txn reset-in-wait: LW addr=00000500 abandoned, rsp_valid=%0b", rsp_valid);

    // Misaligned word load crossing the word boundary
    issue(1'b1, 1'b0, 3'b010, 32'h103, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("split_b1_req", {63'd0, mem_req}, 64'd1);
    chk("split_b1_addr", 64'(mem_addr), 64'h100);
    chk("split_b1_mask", 64'(mem_mask), 64'h08);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11AA_BBCC;
    step();
    mem_rvalid = 1'b0;
    chk("split_b2_req", {63'd0, mem_req}, 64'd1);
    chk("split_b2_addr", 64'(mem_addr), 64'h104);
    chk("split_b2_mask", 64'(mem_mask), 64'h07);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hEE44_3322;
    step();
    mem_rvalid = 1'b0;
    chk("split_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("split_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("split_rsp_rdata", 64'(rsp_rdata), 64'h4433_2211);
`else
    chk("misalign_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("misalign_rsp_err", {63'd0, rsp_err}, 64'd1);
    chk("misalign_no_req", {63'd0, mem_req}, 64'd0);
`endif
    $display("txn misaligned LW addr=00000103 rsp_err=%0b rsp_rdata=%h", rsp_err, rsp_rdata);
    step();
    chk("misalign_end", {63'd0, rsp_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
